// File: rtl/pe_conv1d_v2.sv
// Row-stationary 1D convolution PE: local weight/activation files, strided MAC loop,
// and a valid/ready systolic drain that optionally chains psums from the PE below.
module pe_conv1d_v2 #(
    parameter int DATA_W    = 8,
    parameter int W_DEPTH   = 16,
    parameter int A_DEPTH   = 32,
    parameter int ACC_GUARD = 4,
    localparam int PSUM_W   = 2 * DATA_W + ACC_GUARD,
    localparam int WC_W     = $clog2(W_DEPTH + 1),
    localparam int AC_W     = $clog2(A_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              w_valid_i,
    output logic              w_ready_o,
    input  logic [DATA_W-1:0] w_data_i,
    input  logic              a_valid_i,
    output logic              a_ready_o,
    input  logic [DATA_W-1:0] a_data_i,
    input  logic [WC_W-1:0]   cfg_wcount,
    input  logic [AC_W-1:0]   cfg_acount,
    input  logic [3:0]        cfg_stride,
    input  logic              cfg_signed,
    input  logic              cfg_chain_en,
    input  logic              cfg_keep_w,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              start_err_o,
    input  logic              psum_in_valid_i,
    output logic              psum_in_ready_o,
    input  logic [PSUM_W-1:0] psum_in_i,
    output logic              psum_out_valid_o,
    input  logic              psum_out_ready_i,
    output logic [PSUM_W-1:0] psum_out_o
);

    localparam int WI_W   = $clog2(W_DEPTH);
    localparam int AI_W   = $clog2(A_DEPTH);
    localparam int BASE_W = AC_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t state_r, state_s;

    logic [DATA_W-1:0] w_mem [W_DEPTH];
    logic [DATA_W-1:0] a_mem [A_DEPTH];
    logic [PSUM_W-1:0] p_mem [A_DEPTH];

    logic [WC_W-1:0]   w_cnt_r, k_cfg_r, tap_r;
    logic [AC_W-1:0]   a_cnt_r, l_cfg_r, o_r, d_r;
    logic [3:0]        s_cfg_r;
    logic              signed_r, chain_r, keep_r;
    logic [BASE_W-1:0] base_r;
    logic [PSUM_W-1:0] acc_r;
    logic              done_r, start_err_r;

    logic              w_fire_s, a_fire_s, start_ok_s;
    logic              last_tap_s, last_out_s, last_drain_s, out_fire_s;
    logic [BASE_W-1:0] next_base_s;
    logic [AI_W-1:0]   a_idx_s;
    logic [PSUM_W-1:0] prod_s, acc_sum_s, drain_sum_s;

    // Operand extension to the accumulator width; low PSUM_W bits of the product are exact.
    function automatic logic [PSUM_W-1:0] ext_op(input logic [DATA_W-1:0] v, input logic sgn);
        logic [PSUM_W-1:0] r;
        if (sgn) begin
            r = {{(PSUM_W-DATA_W){v[DATA_W-1]}}, v};
        end else begin
            r = {{(PSUM_W-DATA_W){1'b0}}, v};
        end
        return r;
    endfunction

    assign busy_o      = (state_r != ST_IDLE);
    assign done_o      = done_r;
    assign start_err_o = start_err_r;

    // Handshakes, start legality, MAC datapath and drain outputs.
    always_comb begin
        w_ready_o        = (state_r == ST_IDLE) && (w_cnt_r < cfg_wcount);
        a_ready_o        = (state_r == ST_IDLE) && (a_cnt_r < cfg_acount);
        w_fire_s         = w_valid_i && w_ready_o;
        a_fire_s         = a_valid_i && a_ready_o;
        start_ok_s       = (cfg_wcount != '0) && (cfg_stride != 4'd0)
                           && (32'(cfg_wcount) <= 32'(cfg_acount))
                           && (32'(cfg_acount) <= 32'(A_DEPTH))
                           && (32'(cfg_wcount) <= 32'(W_DEPTH))
                           && (w_cnt_r == cfg_wcount) && (a_cnt_r == cfg_acount);
        a_idx_s          = AI_W'(base_r) + AI_W'(tap_r);
        prod_s           = ext_op(w_mem[tap_r[WI_W-1:0]], signed_r)
                           * ext_op(a_mem[a_idx_s], signed_r);
        if (tap_r == '0) begin
            acc_sum_s = prod_s;
        end else begin
            acc_sum_s = acc_r + prod_s;
        end
        last_tap_s       = (tap_r == k_cfg_r - WC_W'(1));
        next_base_s      = base_r + BASE_W'(s_cfg_r);
        last_out_s       = (next_base_s + BASE_W'(k_cfg_r)) > BASE_W'(l_cfg_r);
        last_drain_s     = (d_r == o_r - AC_W'(1));
        drain_sum_s      = p_mem[d_r[AI_W-1:0]];
        psum_out_valid_o = 1'b0;
        psum_in_ready_o  = 1'b0;
        psum_out_o       = '0;
        if (state_r == ST_DRAIN) begin
            if (chain_r) begin
                psum_out_valid_o = psum_in_valid_i;
                psum_in_ready_o  = psum_out_ready_i;
                psum_out_o       = drain_sum_s + psum_in_i;
            end else begin
                psum_out_valid_o = 1'b1;
                psum_in_ready_o  = 1'b0;
                psum_out_o       = drain_sum_s;
            end
        end else begin
            psum_out_o = '0;
        end
        out_fire_s = psum_out_valid_o && psum_out_ready_i;
    end

    // Next-state selection.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i && start_ok_s) begin
                    state_s = ST_COMPUTE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                if (last_tap_s && last_out_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_COMPUTE;
                end
            end
            ST_DRAIN: begin
                if (out_fire_s && last_drain_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Control state, counters and latched run configuration.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r     <= ST_IDLE;
            w_cnt_r     <= '0;
            a_cnt_r     <= '0;
            k_cfg_r     <= '0;
            l_cfg_r     <= '0;
            s_cfg_r     <= 4'd0;
            signed_r    <= 1'b0;
            chain_r     <= 1'b0;
            keep_r      <= 1'b0;
            tap_r       <= '0;
            base_r      <= '0;
            o_r         <= '0;
            d_r         <= '0;
            acc_r       <= '0;
            done_r      <= 1'b0;
            start_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            done_r      <= 1'b0;
            start_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (w_fire_s) w_cnt_r <= w_cnt_r + WC_W'(1);
                    if (a_fire_s) a_cnt_r <= a_cnt_r + AC_W'(1);
                    if (start_i) begin
                        if (start_ok_s) begin
                            k_cfg_r  <= cfg_wcount;
                            l_cfg_r  <= cfg_acount;
                            s_cfg_r  <= cfg_stride;
                            signed_r <= cfg_signed;
                            chain_r  <= cfg_chain_en;
                            keep_r   <= cfg_keep_w;
                            tap_r    <= '0;
                            base_r   <= '0;
                            o_r      <= '0;
                            d_r      <= '0;
                        end else begin
                            start_err_r <= 1'b1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    acc_r <= acc_sum_s;
                    if (last_tap_s) begin
                        tap_r  <= '0;
                        base_r <= next_base_s;
                        o_r    <= o_r + AC_W'(1);
                    end else begin
                        tap_r <= tap_r + WC_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (out_fire_s) begin
                        if (last_drain_s) begin
                            done_r  <= 1'b1;
                            d_r     <= '0;
                            a_cnt_r <= '0;
                            w_cnt_r <= keep_r ? w_cnt_r : '0;
                        end else begin
                            d_r <= d_r + AC_W'(1);
                        end
                    end
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    // Register files; out-of-range load beats are dropped rather than aliased.
    always_ff @(posedge clk) begin
        if (w_fire_s && (32'(w_cnt_r) < 32'(W_DEPTH))) w_mem[w_cnt_r[WI_W-1:0]] <= w_data_i;
        if (a_fire_s && (32'(a_cnt_r) < 32'(A_DEPTH))) a_mem[a_cnt_r[AI_W-1:0]] <= a_data_i;
        if ((state_r == ST_COMPUTE) && last_tap_s) p_mem[o_r[AI_W-1:0]] <= acc_sum_s;
    end

endmodule

// File: tb/tb_pe_conv1d_v2.sv
// Self-checking bench for pe_conv1d_v2: table-driven directed runs, hand sequences
// for rejection/retention/reset, and randomized runs against an arithmetic model.
module tb_pe_conv1d_v2;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        w_valid_i = 1'b0, a_valid_i = 1'b0;
    logic        w_ready_o, a_ready_o;
    logic [7:0]  w_data_i = 8'd0, a_data_i = 8'd0;
    logic [4:0]  cfg_wcount = 5'd0;
    logic [5:0]  cfg_acount = 6'd0;
    logic [3:0]  cfg_stride = 4'd1;
    logic        cfg_signed = 1'b0, cfg_chain_en = 1'b0, cfg_keep_w = 1'b0;
    logic        start_i = 1'b0;
    logic        busy_o, done_o, start_err_o;
    logic        psum_in_valid_i = 1'b0, psum_in_ready_o;
    logic [19:0] psum_in_i = 20'd0;
    logic        psum_out_valid_o, psum_out_ready_i = 1'b0;
    logic [19:0] psum_out_o;

    pe_conv1d_v2 dut (
        .clk(clk), .nrst(nrst),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_data_i(a_data_i),
        .cfg_wcount(cfg_wcount), .cfg_acount(cfg_acount), .cfg_stride(cfg_stride),
        .cfg_signed(cfg_signed), .cfg_chain_en(cfg_chain_en), .cfg_keep_w(cfg_keep_w),
        .start_i(start_i), .busy_o(busy_o), .done_o(done_o), .start_err_o(start_err_o),
        .psum_in_valid_i(psum_in_valid_i), .psum_in_ready_o(psum_in_ready_o), .psum_in_i(psum_in_i),
        .psum_out_valid_o(psum_out_valid_o), .psum_out_ready_i(psum_out_ready_i), .psum_out_o(psum_out_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]       k;
        logic [5:0]       l;
        logic [3:0]       s;
        logic             sgn, chain, keep, stall;
        logic [4:0][7:0]  w;
        logic [6:0][7:0]  a;
        logic [2:0][19:0] pin;
        int               n;
        logic [2:0][19:0] res;
        int               busy;
    } vec_t;

    vec_t        tbl [6];
    logic [7:0]  wv [16];
    logic [7:0]  av [32];
    int          pin [32];
    int          exp_n;
    logic [19:0] exp_v [32];
    int          got [$];
    int          n_checks = 0, n_pass = 0;

    task automatic check(string name, longint act, longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    function automatic longint opv(logic [7:0] v, bit sgn);
        return sgn ? longint'($signed(v)) : longint'(v);
    endfunction

    // Direct evaluation of o = sum_k w[k]*a[o*S+k] (+ psum_in when chained), mod 2^20.
    task automatic model(int k, int l, int s, bit sgn, bit chain);
        longint acc;
        exp_n = 0;
        for (int o = 0; o * s + k <= l; o++) begin
            acc = 0;
            for (int j = 0; j < k; j++) acc += opv(wv[j], sgn) * opv(av[o * s + j], sgn);
            if (chain) acc += longint'(pin[o]);
            exp_v[o] = acc[19:0];
            exp_n++;
        end
    endtask

    task automatic load(int k, int l, int w_from, int w_to, int a_from, int a_to);
        int wi = w_from, ai = a_from;
        bit wacc, aacc;
        cfg_wcount = 5'(k);
        cfg_acount = 6'(l);
        for (int cyc = 0; cyc < 200 && (wi < w_to || ai < a_to); cyc++) begin
            @(negedge clk);
            w_valid_i = (wi < w_to);
            w_data_i  = wv[wi < 16 ? wi : 0];
            a_valid_i = (ai < a_to);
            a_data_i  = av[ai < 32 ? ai : 0];
            #1;
            wacc = w_valid_i && w_ready_o;
            aacc = a_valid_i && a_ready_o;
            @(posedge clk);
            if (wacc) wi++;
            if (aacc) ai++;
        end
        @(negedge clk);
        w_valid_i = 1'b0;
        a_valid_i = 1'b0;
        check("load_complete", longint'(wi == w_to && ai == a_to), 1);
    endtask

    task automatic run_case(string tag, int k, int l, int s, bit sgn, bit chain, bit keep,
                            bit stall_mode, bit rnd_bp, output int busy_cnt);
        int done_cnt = 0, pidx = 0, stall = 0, post = 0;
        bit first_done = 0;
        got.delete();
        busy_cnt = 0;
        @(negedge clk);
        cfg_wcount = 5'(k); cfg_acount = 6'(l); cfg_stride = 4'(s);
        cfg_signed = sgn; cfg_chain_en = chain; cfg_keep_w = keep;
        start_i = 1'b1;
        for (int cyc = 0; cyc < 3000 && post < 3; cyc++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (rnd_bp && busy_o) begin
                cfg_stride   = 4'($urandom_range(0, 15));
                cfg_signed   = 1'($urandom_range(0, 1));
                cfg_chain_en = 1'($urandom_range(0, 1));
                cfg_keep_w   = 1'($urandom_range(0, 1));
            end
            psum_out_ready_i = rnd_bp ? ($urandom_range(0, 3) != 0) : (stall == 0);
            if (stall > 0) stall--;
            psum_in_valid_i = rnd_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            psum_in_i = 20'(pin[pidx]);
            #1;
            if (busy_o) busy_cnt++;
            if (done_o) begin done_cnt++; first_done = 1; end
            if (first_done) post++;
            if (stall_mode && !psum_out_ready_i && busy_o && got.size() > 0 && got.size() < exp_n) begin
                check({tag, "_stall_hold"}, longint'(psum_out_o), longint'(exp_v[got.size()]));
                check({tag, "_stall_in_ready"}, longint'(psum_in_ready_o), 0);
            end
            if (psum_out_valid_o && psum_out_ready_i) begin
                got.push_back(int'(psum_out_o));
                if (chain && pidx < 31) pidx++;
                if (stall_mode && got.size() == 1) stall = 2;
            end
        end
        psum_in_valid_i = 1'b0;
        psum_out_ready_i = 1'b0;
        check({tag, "_finished"}, longint'(first_done), 1);
        check({tag, "_count"}, longint'(got.size()), longint'(exp_n));
        for (int i = 0; i < exp_n; i++)
            check({tag, "_psum"}, (i < got.size()) ? longint'(got[i]) : -1, longint'(exp_v[i]));
        check({tag, "_done_pulses"}, longint'(done_cnt), 1);
    endtask

    initial begin
        int bc;
        int k, l, s;
        // directed vectors with hand-computed results
        tbl[0] = '0; tbl[0].k = 5'd3; tbl[0].l = 6'd5; tbl[0].s = 4'd1; tbl[0].n = 3; tbl[0].busy = 12;
        for (int j = 0; j < 3; j++) tbl[0].w[j] = 8'(j + 1);
        for (int j = 0; j < 7; j++) tbl[0].a[j] = 8'(j + 1);
        tbl[0].res[0] = 20'd14; tbl[0].res[1] = 20'd20; tbl[0].res[2] = 20'd26;
        tbl[1] = tbl[0]; tbl[1].l = 6'd7; tbl[1].s = 4'd2;
        tbl[1].res[0] = 20'd14; tbl[1].res[1] = 20'd26; tbl[1].res[2] = 20'd38;
        tbl[2] = '0; tbl[2].k = 5'd2; tbl[2].l = 6'd3; tbl[2].s = 4'd1; tbl[2].sgn = 1'b1;
        tbl[2].n = 2; tbl[2].busy = 6;
        tbl[2].w[0] = 8'hFF; tbl[2].w[1] = 8'h02;
        tbl[2].a[0] = 8'h03; tbl[2].a[1] = 8'hFC; tbl[2].a[2] = 8'h05;
        tbl[2].res[0] = 20'hFFFF5; tbl[2].res[1] = 20'd14;
        tbl[3] = tbl[2]; tbl[3].sgn = 1'b0; tbl[3].res[0] = 20'd1269; tbl[3].res[1] = 20'd64270;
        tbl[4] = tbl[0]; tbl[4].chain = 1'b1; tbl[4].stall = 1'b1; tbl[4].busy = 14;
        tbl[4].pin[0] = 20'd100; tbl[4].pin[1] = 20'd200; tbl[4].pin[2] = 20'd300;
        tbl[4].res[0] = 20'd114; tbl[4].res[1] = 20'd220; tbl[4].res[2] = 20'd326;
        tbl[5] = tbl[0]; tbl[5].keep = 1'b1;

        for (int j = 0; j < 32; j++) pin[j] = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", longint'(busy_o), 0);
        check("rst_done", longint'(done_o), 0);
        check("rst_start_err", longint'(start_err_o), 0);
        check("rst_out_valid", longint'(psum_out_valid_o), 0);
        check("rst_in_ready", longint'(psum_in_ready_o), 0);
        check("rst_out", longint'(psum_out_o), 0);
        nrst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 16; j++) wv[j] = (j < 5) ? tbl[i].w[j] : 8'd0;
            for (int j = 0; j < 32; j++) av[j] = (j < 7) ? tbl[i].a[j] : 8'd0;
            for (int j = 0; j < 3; j++) pin[j] = int'(tbl[i].pin[j]);
            exp_n = tbl[i].n;
            for (int j = 0; j < 3; j++) exp_v[j] = tbl[i].res[j];
            load(int'(tbl[i].k), int'(tbl[i].l), 0, int'(tbl[i].k), 0, int'(tbl[i].l));
            run_case($sformatf("vec%0d", i), int'(tbl[i].k), int'(tbl[i].l), int'(tbl[i].s),
                     tbl[i].sgn, tbl[i].chain, tbl[i].keep, tbl[i].stall, 1'b0, bc);
            check($sformatf("vec%0d_busy_cycles", i), longint'(bc), longint'(tbl[i].busy));
        end

        // weights retained from vec5: only activations are reloaded
        cfg_wcount = 5'd3; cfg_acount = 6'd5;
        #1;
        check("keep_w_ready", longint'(w_ready_o), 0);
        for (int j = 0; j < 5; j++) av[j] = 8'd2;
        load(3, 5, 0, 0, 0, 5);
        exp_n = 3; exp_v[0] = 20'd12; exp_v[1] = 20'd12; exp_v[2] = 20'd12;
        run_case("keep_run", 3, 5, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, bc);

        // rejected starts
        @(negedge clk);
        cfg_wcount = 5'd4; cfg_acount = 6'd3; cfg_stride = 4'd1; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0; #1;
        check("rej_k_gt_l_err", longint'(start_err_o), 1);
        check("rej_k_gt_l_busy", longint'(busy_o), 0);
        @(negedge clk); #1;
        check("rej_err_one_cycle", longint'(start_err_o), 0);
        for (int j = 0; j < 3; j++) wv[j] = 8'(j + 1);
        for (int j = 0; j < 5; j++) av[j] = 8'(j + 1);
        load(3, 5, 0, 3, 0, 2);
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0; #1;
        check("rej_partial_err", longint'(start_err_o), 1);
        check("rej_partial_busy", longint'(busy_o), 0);
        load(3, 5, 3, 3, 2, 5);
        exp_n = 3; exp_v[0] = 20'd14; exp_v[1] = 20'd20; exp_v[2] = 20'd26;
        run_case("after_rej", 3, 5, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, bc);

        // randomized runs with backpressure; first two pin the size boundaries
        for (int r = 0; r < 14; r++) begin
            if (r == 0) begin k = 16; l = 32; s = 15; end
            else if (r == 1) begin k = 5; l = 5; s = 3; end
            else begin
                k = $urandom_range(1, 6);
                l = $urandom_range(k, 20);
                s = $urandom_range(1, 4);
            end
            for (int j = 0; j < 16; j++) wv[j] = 8'($urandom_range(0, 255));
            for (int j = 0; j < 32; j++) av[j] = 8'($urandom_range(0, 255));
            for (int j = 0; j < 32; j++) pin[j] = int'($urandom_range(0, 20'hFFFFF));
            begin
                bit sg = 1'($urandom_range(0, 1));
                bit ch = 1'($urandom_range(0, 1));
                model(k, l, s, sg, ch);
                load(k, l, 0, k, 0, l);
                run_case($sformatf("rnd%0d", r), k, l, s, sg, ch, 1'b0, 1'b0, 1'b1, bc);
            end
        end

        // asynchronous reset in the middle of COMPUTE
        for (int j = 0; j < 3; j++) wv[j] = 8'(j + 1);
        for (int j = 0; j < 5; j++) av[j] = 8'(j + 1);
        load(3, 5, 0, 3, 0, 5);
        @(negedge clk);
        cfg_stride = 4'd1; cfg_chain_en = 1'b0; cfg_keep_w = 1'b0; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("midrst_busy_before", longint'(busy_o), 1);
        nrst = 1'b0;
        #1;
        check("midrst_busy", longint'(busy_o), 0);
        check("midrst_out_valid", longint'(psum_out_valid_o), 0);
        @(negedge clk);
        nrst = 1'b1;
        begin
            int dn = 0, bz = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk); #1;
                if (done_o) dn++;
                if (busy_o) bz++;
            end
            check("midrst_no_done", longint'(dn), 0);
            check("midrst_idle", longint'(bz), 0);
        end
        cfg_wcount = 5'd3;
        #1;
        check("midrst_w_ready", longint'(w_ready_o), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
